reg_share_arb: RTL and testbench
================================

# reg_share_arb

Round-robin arbiter that shares one W-bit register, built from the team's negative-edge DFF cells, among NREQ requesters. Each requester raises a request with its write data. The arbiter grants exactly one requester at a time, loads that requester's data into the shared register, and reports which requester wrote last. It sits between the requester logic and the shared register bank and is the only block that drives the register's data input.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 8, shared register width
- c  in  1  clock; all state updates on the falling edge of c
- r  in  1  reset; synchronous, active-high, sampled on the falling edge of c
- req  in  NREQ  per-requester write request, level
- din  in  NREQ*W  write data; requester i occupies din[i*W +: W]
- lock  in  NREQ  per-requester hold-ownership request; present only with REG_SHARE_LOCK_EN
- gnt  out  NREQ  one-hot grant, registered
- q  out  W  shared register contents
- owner  out  clog2(NREQ)  index of the requester whose data is in q
- valid  out  1  high once q has been written since reset
- busy  out  1  high whenever state is not IDLE

## Operation
- State register and round-robin pointer ptr (clog2(NREQ) bits).
- States: IDLE, WRITE, and HOLD (HOLD exists only with the macro).
- **IDLE:** if any req is high at an edge:
  - winner = first set req index searching ptr, ptr+1, … mod NREQ.
  - gnt <= onehot(winner); state <= WRITE; busy <= 1.
  - If no req is high: no change.
- **WRITE:** at the next edge:
  - q <= din slice of the winner; owner <= winner; valid <= 1; ptr <= (winner+1) mod NREQ.
  - Then either gnt <= 0 and state <= IDLE, or HOLD (see Configuration).
  - req is not sampled in WRITE. A req change during WRITE does not cancel the write.
- Requester protocol:
  - Hold req high until gnt is seen. Drop req on or after the edge that clears gnt.
  - A req still high in the first IDLE cycle after a write is a new request, arbitrated against the others with the updated ptr.
- gnt is never multi-hot. gnt is nonzero only in WRITE and HOLD.
- q changes only on WRITE and HOLD edges. Otherwise it holds its value.
- Ties among requesters are resolved only by ptr; there is no fixed priority.

## Timing
- Reset values: q=0, gnt=0, owner=0, valid=0, busy=0, ptr=0, state=IDLE.
- r high at any edge forces reset values at that edge, including mid-WRITE or mid-HOLD. No load of q occurs at that edge.
- Latency: req seen at edge k -> gnt high after edge k -> q updated at edge k+1 -> gnt low after edge k+1.
- Peak throughput: one write per 2 cycles.
- Starvation bound: a requester holding req high is granted within NREQ arbitrations.
- Wrap-around: ptr goes from NREQ-1 to 0.
- Single requester asserting req continuously: granted every 2 cycles.
- All outputs are registered; there is no combinational path from req or din to any output.

## Configuration
- Macro: REG_SHARE_LOCK_EN.
- **Defined:**
  - lock port is present.
  - At the WRITE edge, if lock[winner]=1: state <= HOLD, gnt stays asserted.
  - In HOLD, at every edge, q <= din[winner].
  - At the first HOLD edge where lock[winner]=0: that final load occurs, gnt <= 0, state <= IDLE.
  - ptr is updated at the WRITE edge only.
  - Other requests wait while in HOLD.
- **Undefined:**
  - No lock port and no HOLD state.
  - WRITE always returns to IDLE after one load.

## Test plan
1. **Reset:** r=1 for 2 edges with req=4'b1111. Expect q=0, gnt=0, valid=0, busy=0.
2. **Single write:** r=1 for 2 edges, then r=0; req=4'b0100, din[23:16]=8'hA5. Expect:
   - After the next edge: gnt=4'b0100, busy=1.
   - After the following edge: q=8'hA5, owner=2, valid=1, gnt=0.
3. **Round-robin:** req=4'b1111 held; slice i = 8'h10+i. Expect grants 0,1,2,3,0 on successive 2-cycle slots and q sequence 10,11,12,13,10.
4. **Mid-operation reset:** r=1 at the WRITE edge of a grant to requester 1. Expect q unchanged at 0, gnt=0, state IDLE, ptr=0. Next grant with req=4'b0011 goes to requester 0.
5. **Lock (macro defined):** requester 3 granted with lock[3]=1 for 3 edges while din slice counts 1,2,3; req[0]=1 throughout. Expect:
   - q follows 1,2,3.
   - gnt stays 4'b1000 until lock drops.
   - Then gnt=4'b0001 two edges later.
6. **Lock (macro undefined):** same stimulus without lock. Expect gnt[3] for one cycle only, then requester 0 granted.

Source files
------------

// File: rtl/reg_share_arb.sv
// Round-robin arbiter sharing one W-bit register among NREQ requesters; state updates on the falling edge of c.
// Optional ownership hold (lock port, HOLD state) is enabled with `define REG_SHARE_LOCK_EN.
module reg_share_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8
) (
    input  logic                      c,
    input  logic                      r,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*W-1:0]         din,
`ifdef REG_SHARE_LOCK_EN
    input  logic [NREQ-1:0]           lock,
`endif
    output logic [NREQ-1:0]           gnt,
    output logic [W-1:0]              q,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      valid,
    output logic                      busy
);

    localparam int unsigned PW = $clog2(NREQ);

`ifdef REG_SHARE_LOCK_EN
    typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, WRITE} state_t;
`endif

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic [PW-1:0]   win, win_nxt;
    logic [NREQ-1:0] gnt_nxt;
    logic [W-1:0]    q_nxt;
    logic [PW-1:0]   owner_nxt;
    logic            valid_nxt;
    logic            busy_nxt;
    logic [PW-1:0]   pick;
    logic [W-1:0]    slice [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign slice[i] = din[i*W +: W];
    end

    // Scanning from the far end lets the match closest to ptr overwrite the others.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] rq, input logic [PW-1:0] p);
        logic [PW-1:0] res;
        int            idx;
        res = p;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % int'(NREQ);
            if (rq[idx]) res = PW'(idx);
        end
        return res;
    endfunction

    assign pick = rr_pick(req, ptr);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_nxt = state;
        ptr_nxt   = ptr;
        win_nxt   = win;
        gnt_nxt   = gnt;
        q_nxt     = q;
        owner_nxt = owner;
        valid_nxt = valid;
        case (state)
            IDLE: begin
                if (|req) begin
                    win_nxt       = pick;
                    gnt_nxt       = '0;
                    gnt_nxt[pick] = 1'b1;
                    state_nxt     = WRITE;
                end
            end
            WRITE: begin
                q_nxt     = slice[win];
                owner_nxt = win;
                valid_nxt = 1'b1;
                ptr_nxt   = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                gnt_nxt   = '0;
                state_nxt = IDLE;
`ifdef REG_SHARE_LOCK_EN
                if (lock[win]) begin
                    gnt_nxt   = gnt;
                    state_nxt = HOLD;
                end
`endif
            end
`ifdef REG_SHARE_LOCK_EN
            HOLD: begin
                // The load on the releasing edge still happens; only ownership ends.
                q_nxt = slice[win];
                if (!lock[win]) begin
                    gnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
`endif
            default: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(negedge c) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
        if (r) begin
            state <= IDLE;
            ptr   <= '0;
            win   <= '0;
            gnt   <= '0;
            q     <= '0;
            owner <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            win   <= win_nxt;
            gnt   <= gnt_nxt;
            q     <= q_nxt;
            owner <= owner_nxt;
            valid <= valid_nxt;
            busy  <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_reg_share_arb.sv
// Directed bench for reg_share_arb: reset, single write, round-robin, mid-write reset, and lock/no-lock behaviour.
// Inputs change and outputs are sampled on the rising edge, opposite the falling active edge.
module tb_reg_share_arb;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic              c = 1'b0;
    logic              r;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] din;
    logic [NREQ-1:0]   lock;
    logic [NREQ-1:0]   gnt;
    logic [W-1:0]      q;
    logic [1:0]        owner;
    logic              valid;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 c = ~c;

    reg_share_arb #(.NREQ(NREQ), .W(W)) dut (
        .c     (c),
        .r     (r),
        .req   (req),
        .din   (din),
`ifdef REG_SHARE_LOCK_EN
        .lock  (lock),
`endif
        .gnt   (gnt),
        .q     (q),
        .owner (owner),
        .valid (valid),
        .busy  (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One active (falling) edge, then park on the following rising edge.
    task automatic step();
        @(negedge c);
        @(posedge c);
    endtask

    task automatic do_reset();
        r   = 1'b1;
        req = '0;
        step();
        r = 1'b0;
    endtask

    initial begin
        r    = 1'b1;
        req  = '0;
        din  = '0;
        lock = '0;
        @(posedge c);

        // Reset with all requests high
        req = 4'b1111;
        step();
        step();
        check("rst_q",     32'(q),     32'h0);
        check("rst_gnt",   32'(gnt),   32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_owner", 32'(owner), 32'h0);

        // Single write from requester 2
        r   = 1'b0;
        req = 4'b0100;
        din[2*W +: W] = 8'hA5;
        step();
        check("sw_gnt",  32'(gnt),  32'b0100);
        check("sw_busy", 32'(busy), 32'h1);
        check("sw_q_pre", 32'(q),   32'h0);
        step();
        req = 4'b0000;
        check("sw_q",     32'(q),     32'hA5);
        check("sw_owner", 32'(owner), 32'h2);
        check("sw_valid", 32'(valid), 32'h1);
        check("sw_gnt0",  32'(gnt),   32'h0);
        step();
        step();
        check("sw_hold_q", 32'(q),    32'hA5);
        check("sw_idle",   32'(busy), 32'h0);

        // Round-robin with every requester active, including wrap-around
        do_reset();
        for (int i = 0; i < NREQ; i++) din[i*W +: W] = 8'(8'h10 + i);
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            step();
            check($sformatf("rr_gnt%0d", n), 32'(gnt), 32'(1 << (n % NREQ)));
            step();
            check($sformatf("rr_q%0d", n),     32'(q),     32'(8'h10 + (n % NREQ)));
            check($sformatf("rr_own%0d", n),   32'(owner), 32'(n % NREQ));
            check($sformatf("rr_gclr%0d", n),  32'(gnt),   32'h0);
        end

        // Reset at the WRITE edge of a grant to requester 1
        do_reset();
        for (int i = 0; i < NREQ; i++) din[i*W +: W] = 8'(8'h20 + i);
        req = 4'b0010;
        step();
        check("mr_gnt1", 32'(gnt), 32'b0010);
        r = 1'b1;
        step();
        r = 1'b0;
        check("mr_q",     32'(q),     32'h0);
        check("mr_gnt",   32'(gnt),   32'h0);
        check("mr_busy",  32'(busy),  32'h0);
        check("mr_valid", 32'(valid), 32'h0);
        req = 4'b0011;
        step();
        check("mr_next_gnt", 32'(gnt), 32'b0001);
        step();
        req = 4'b0000;
        check("mr_next_q",   32'(q),     32'h20);
        check("mr_next_own", 32'(owner), 32'h0);

`ifdef REG_SHARE_LOCK_EN
        // Requester 3 holds ownership for three loads; requester 0 waits
        do_reset();
        req  = 4'b1000;
        lock = 4'b1000;
        din  = '0;
        din[0*W +: W] = 8'h55;
        din[3*W +: W] = 8'h01;
        step();
        check("lk_gnt", 32'(gnt), 32'b1000);
        req = 4'b1001;
        for (int n = 1; n <= 3; n++) begin
            din[3*W +: W] = 8'(n);
            step();
            check($sformatf("lk_q%0d", n),    32'(q),    32'(n));
            check($sformatf("lk_gnt%0d", n),  32'(gnt),  32'b1000);
            check($sformatf("lk_busy%0d", n), 32'(busy), 32'h1);
        end
        lock = 4'b0000;
        step();
        req = 4'b0001;
        check("lk_rel_q",   32'(q),   32'h3);
        check("lk_rel_gnt", 32'(gnt), 32'h0);
        step();
        check("lk_next_gnt", 32'(gnt), 32'b0001);
        step();
        check("lk_next_q",   32'(q),     32'h55);
        check("lk_next_own", 32'(owner), 32'h0);
`else
        // Same stimulus without lock: requester 3 owns for one write only
        do_reset();
        req = 4'b1000;
        din = '0;
        din[0*W +: W] = 8'h55;
        din[3*W +: W] = 8'h01;
        step();
        check("nl_gnt", 32'(gnt), 32'b1000);
        req = 4'b1001;
        din[3*W +: W] = 8'h02;
        step();
        req = 4'b0001;
        check("nl_q",     32'(q),     32'h02);
        check("nl_own",   32'(owner), 32'h3);
        check("nl_gnt0",  32'(gnt),   32'h0);
        step();
        check("nl_next_gnt", 32'(gnt), 32'b0001);
        step();
        check("nl_next_q",   32'(q),     32'h55);
        check("nl_next_own", 32'(owner), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
